// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port between writeback sources
module rf_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*AW-1:0]     req_rd,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  input  logic                    wb_hold,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_rd,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [2:0]              grant_id,
  output logic                    wb_busy
);
  logic [N_REQ-1:0] real_v;
  logic             active, gnt_found;
  logic [2:0]       gnt_idx;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic [2:0]       grant_id_q, grant_id_d;
  always_comb begin
    active = rst_n & ~wb_hold;
    for (int i = 0; i < N_REQ; i++) real_v[i] = req_valid[i] & (req_rd[i*AW +: AW] != '0);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    // first real request found walking forward from rr_ptr wins the port
    for (int k = 0; k < N_REQ; k++)
      if (!gnt_found && real_v[(int'(rr_ptr_q) + k) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'((int'(rr_ptr_q) + k) % N_REQ);
      end
    // zero-rd requests need no port, so they complete alongside any grant
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = active & req_valid[i] & (~real_v[i] | (gnt_found & (gnt_idx == 3'(i))));
    rf_we_d    = active & gnt_found;
    rr_ptr_d   = rf_we_d ? ((gnt_idx == 3'(N_REQ-1)) ? 3'd0 : gnt_idx + 3'd1) : rr_ptr_q;
    rf_rd_d    = rf_we_d ? req_rd[gnt_idx*AW +: AW] : rf_rd_q;
    rf_wdata_d = rf_we_d ? req_data[gnt_idx*XLEN +: XLEN] : rf_wdata_q;
    grant_id_d = rf_we_d ? gnt_idx : grant_id_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
    end
  end
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = grant_id_q;
  assign wb_busy  = |req_valid;
endmodule
